// File: rtl/crem_cmd_pkg.sv
// Shared definitions for the UART command-frame decoder: opcodes, FSM states
// and the fixed register-file addresses used for ALU operands.
package crem_cmd_pkg;

   localparam logic [7:0] CMD_RF_WR   = 8'hAA;
   localparam logic [7:0] CMD_RF_RD   = 8'hBB;
   localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
   localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

   localparam int unsigned OPA_ADDR = 0;
   localparam int unsigned OPB_ADDR = 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_ADDR,
      ST_WR_DATA,
      ST_RD_ADDR,
      ST_OP_A,
      ST_OP_B,
      ST_FUN
   } cmd_state_t;

endpackage

// File: rtl/frame_timeout_cnt.sv
// Inter-byte watchdog: counts clocks since the last byte while a frame is open
// and raises a one-cycle expired when the count reaches TIMEOUT-1.
module frame_timeout_cnt #(
   parameter int TIMEOUT = 4096
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic clr,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT);

   logic [CNT_W-1:0] cnt;

   // A byte in the expiry cycle masks the expiry, so the byte always wins.
   assign expired = run && !clr && (cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr || !run || expired) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/cmd_frame_decoder.sv
// Byte-stream command parser behind the UART receiver; turns framed commands
// into single-cycle register-file and ALU strobes.
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | waiting for an opcode byte
// ST_WR_ADDR | RF write: expecting address byte
// ST_WR_DATA | RF write: expecting data byte, then strobe
// ST_RD_ADDR | RF read: expecting address byte, then strobe
// ST_OP_A    | ALU op: expecting operand A (written to addr 0)
// ST_OP_B    | ALU op: expecting operand B (written to addr 1)
// ST_FUN     | ALU: expecting function byte, then ALU strobe
module cmd_frame_decoder
   import crem_cmd_pkg::*;
#(
   parameter int ADDR_W  = 4,
   parameter int FUN_W   = 4,
   parameter int TIMEOUT = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rf_wr_en,
   output logic              rf_rd_en,
   output logic [ADDR_W-1:0] rf_addr,
   output logic [7:0]        rf_wr_data,
   output logic              alu_en,
   output logic [FUN_W-1:0]  alu_fun,
   output logic              cmd_err,
   output logic              busy
);

   cmd_state_t        state;
   logic [ADDR_W-1:0] addr_lat;
   logic              run;
   logic              expired;

   assign run = (state != ST_IDLE);

   frame_timeout_cnt #(
      .TIMEOUT(TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .run     (run),
      .clr     (rx_valid),
      .expired (expired)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         addr_lat   <= '0;
         rf_wr_en   <= 1'b0;
         rf_rd_en   <= 1'b0;
         rf_addr    <= '0;
         rf_wr_data <= '0;
         alu_en     <= 1'b0;
         alu_fun    <= '0;
         cmd_err    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         rf_wr_en <= 1'b0;
         rf_rd_en <= 1'b0;
         alu_en   <= 1'b0;
         cmd_err  <= 1'b0;
         if (rx_valid) begin
            case (state)
               ST_IDLE: begin
                  case (rx_data)
                     CMD_RF_WR:   begin state <= ST_WR_ADDR; busy <= 1'b1; end
                     CMD_RF_RD:   begin state <= ST_RD_ADDR; busy <= 1'b1; end
                     CMD_ALU_OP:  begin state <= ST_OP_A;    busy <= 1'b1; end
                     CMD_ALU_NOP: begin state <= ST_FUN;     busy <= 1'b1; end
                     default:     cmd_err <= 1'b1;
                  endcase
               end
               ST_WR_ADDR: begin
                  addr_lat <= rx_data[ADDR_W-1:0];
                  state    <= ST_WR_DATA;
               end
               ST_WR_DATA: begin
                  rf_wr_en   <= 1'b1;
                  rf_addr    <= addr_lat;
                  rf_wr_data <= rx_data;
                  state      <= ST_IDLE;
                  busy       <= 1'b0;
               end
               ST_RD_ADDR: begin
                  rf_rd_en <= 1'b1;
                  rf_addr  <= rx_data[ADDR_W-1:0];
                  state    <= ST_IDLE;
                  busy     <= 1'b0;
               end
               ST_OP_A: begin
                  rf_wr_en   <= 1'b1;
                  rf_addr    <= ADDR_W'(OPA_ADDR);
                  rf_wr_data <= rx_data;
                  state      <= ST_OP_B;
               end
               ST_OP_B: begin
                  rf_wr_en   <= 1'b1;
                  rf_addr    <= ADDR_W'(OPB_ADDR);
                  rf_wr_data <= rx_data;
                  state      <= ST_FUN;
               end
               ST_FUN: begin
                  alu_en  <= 1'b1;
                  alu_fun <= rx_data[FUN_W-1:0];
                  state   <= ST_IDLE;
                  busy    <= 1'b0;
               end
               default: begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end else if (expired) begin
            // Stalled frame: drop whatever was collected and flag it.
            state    <= ST_IDLE;
            addr_lat <= '0;
            cmd_err  <= 1'b1;
            busy     <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cmd_frame_decoder.sv
// Bench for cmd_frame_decoder: frame-level reference model feeds a scoreboard
// queue; a negedge monitor pops and compares every strobe and the busy flag.
module tb_cmd_frame_decoder;

   localparam int TMO = 16;

   localparam logic [3:0] K_WR  = 4'b1000;
   localparam logic [3:0] K_RD  = 4'b0100;
   localparam logic [3:0] K_ALU = 4'b0010;
   localparam logic [3:0] K_ERR = 4'b0001;

   typedef struct {
      logic [3:0] kind;
      int         cyc;
      logic [3:0] addr;
      logic [7:0] data;
      logic [3:0] fun;
   } ev_t;

   typedef struct {
      int   cyc;
      logic val;
   } busy_t;

   logic       clk;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rf_wr_en;
   logic       rf_rd_en;
   logic [3:0] rf_addr;
   logic [7:0] rf_wr_data;
   logic       alu_en;
   logic [3:0] alu_fun;
   logic       cmd_err;
   logic       busy;

   int    cyc = 0;
   int    n_cmp = 0;
   int    n_err = 0;
   int    gap = 0;
   ev_t   evq[$];
   busy_t bq[$];
   logic [7:0] frame[$];

   cmd_frame_decoder #(
      .ADDR_W  (4),
      .FUN_W   (4),
      .TIMEOUT (TMO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rf_wr_en   (rf_wr_en),
      .rf_rd_en   (rf_rd_en),
      .rf_addr    (rf_addr),
      .rf_wr_data (rf_wr_data),
      .alu_en     (alu_en),
      .alu_fun    (alu_fun),
      .cmd_err    (cmd_err),
      .busy       (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic void push_ev(input logic [3:0] k, input int s, input logic [3:0] a,
                                   input logic [7:0] d, input logic [3:0] f);
      ev_t e;
      e.kind = k; e.cyc = s; e.addr = a; e.data = d; e.fun = f;
      evq.push_back(e);
   endfunction

   // Frame-level reference: collect bytes, emit the command once its length is met.
   function automatic void model_byte(input logic [7:0] b, input int s);
      if (frame.size() == 0) begin
         if (b inside {8'hAA, 8'hBB, 8'hCC, 8'hDD}) frame.push_back(b);
         else push_ev(K_ERR, s, 4'h0, 8'h00, 4'h0);
      end else begin
         frame.push_back(b);
         case (frame[0])
            8'hAA: if (frame.size() == 3) begin
               push_ev(K_WR, s, frame[1][3:0], b, 4'h0);
               frame.delete();
            end
            8'hBB: begin
               push_ev(K_RD, s, b[3:0], 8'h00, 4'h0);
               frame.delete();
            end
            8'hCC: begin
               if (frame.size() == 2) push_ev(K_WR, s, 4'h0, b, 4'h0);
               else if (frame.size() == 3) push_ev(K_WR, s, 4'h1, b, 4'h0);
               else begin
                  push_ev(K_ALU, s, 4'h0, 8'h00, b[3:0]);
                  frame.delete();
               end
            end
            default: begin
               push_ev(K_ALU, s, 4'h0, 8'h00, b[3:0]);
               frame.delete();
            end
         endcase
      end
   endfunction

   task automatic step(input logic v, input logic [7:0] d);
      int s;
      busy_t bt;
      @(posedge clk);
      #1;
      rx_valid = v;
      rx_data  = d;
      s = cyc + 1;
      if (v) begin
         gap = 0;
         model_byte(d, s);
      end else if (frame.size() != 0) begin
         gap++;
         if (gap == TMO) begin
            push_ev(K_ERR, s, 4'h0, 8'h00, 4'h0);
            frame.delete();
            gap = 0;
         end
      end
      bt.cyc = s;
      bt.val = (frame.size() != 0);
      bq.push_back(bt);
   endtask

   task automatic send(input logic [7:0] b, input int idle);
      repeat (idle) step(1'b0, 8'($urandom()));
      step(1'b1, b);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_wr_en"}, rf_wr_en, 0);
      chk({tag, "_rd_en"}, rf_rd_en, 0);
      chk({tag, "_alu_en"}, alu_en, 0);
      chk({tag, "_cmd_err"}, cmd_err, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_rf_addr"}, rf_addr, 0);
      chk({tag, "_rf_wr_data"}, rf_wr_data, 0);
      chk({tag, "_alu_fun"}, alu_fun, 0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      rx_valid = 1'b0;
      frame.delete();
      gap = 0;
      bq.delete();
      #1 chk_zero("midrst");
      repeat (2) @(posedge clk);
      #1 chk_zero("midrst_hold");
      rst = 1'b1;
   endtask

   // Monitor: scoreboard pop on every strobe, busy compared every cycle.
   always @(negedge clk) begin
      if (rst) begin
         while (evq.size() > 0 && evq[0].cyc < cyc) begin
            chk("missing_strobe_cycle", cyc, evq[0].cyc);
            void'(evq.pop_front());
         end
         if (rf_wr_en || rf_rd_en || alu_en || cmd_err) begin
            if (evq.size() == 0) begin
               chk("unexpected_strobe", {rf_wr_en, rf_rd_en, alu_en, cmd_err}, 0);
            end else begin
               ev_t e;
               e = evq.pop_front();
               chk("strobe_cycle", cyc, e.cyc);
               chk("strobe_kind", {rf_wr_en, rf_rd_en, alu_en, cmd_err}, e.kind);
               if (e.kind == K_WR) begin
                  chk("wr_addr", rf_addr, e.addr);
                  chk("wr_data", rf_wr_data, e.data);
               end else if (e.kind == K_RD) begin
                  chk("rd_addr", rf_addr, e.addr);
               end else if (e.kind == K_ALU) begin
                  chk("alu_fun", alu_fun, e.fun);
               end
            end
         end
         while (bq.size() > 0 && bq[0].cyc < cyc) void'(bq.pop_front());
         if (bq.size() > 0 && bq[0].cyc == cyc) begin
            chk("busy", busy, bq[0].val);
            void'(bq.pop_front());
         end
      end
   end

   logic [7:0] ops[4];
   int         lens[4];

   initial begin
      ops  = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      lens = '{3, 2, 4, 2};
      rst = 1'b0;
      rx_valid = 1'b0;
      rx_data = 8'h00;
      repeat (3) @(posedge clk);
      #1 chk_zero("reset");
      rst = 1'b1;

      send(8'hAA, 0); send(8'h05, 0); send(8'h3C, 0);
      send(8'hBB, 2); send(8'h1F, 0);
      send(8'hCC, 2); send(8'h12, 0); send(8'h34, 0); send(8'h07, 0);
      send(8'hCC, 4); send(8'h12, 4); send(8'h34, 4); send(8'h07, 4);
      send(8'h55, 1);
      send(8'hDD, 0); send(8'h03, 0);
      send(8'hAA, 1); send(8'h05, 0);
      repeat (20) step(1'b0, 8'h00);
      send(8'hBB, 0); send(8'h02, 0);
      send(8'hAA, 1); send(8'h05, 0); send(8'h3C, TMO - 1);
      send(8'hCC, 1); send(8'h12, 0);
      step(1'b0, 8'h00);
      do_reset();
      send(8'hBB, 0); send(8'h01, 0);

      for (int f = 0; f < 80; f++) begin
         int r;
         int k;
         r = int'($urandom_range(0, 9));
         if (r < 2) begin
            send(8'($urandom()), int'($urandom_range(0, 3)));
         end else begin
            k = int'($urandom_range(0, 3));
            send(ops[k], int'($urandom_range(0, 3)));
            for (int j = 1; j < lens[k]; j++) begin
               int g;
               int r2;
               r2 = int'($urandom_range(0, 19));
               if (r2 < 12) g = 0;
               else if (r2 < 17) g = int'($urandom_range(1, 5));
               else g = int'($urandom_range(TMO - 2, TMO + 1));
               send(8'($urandom()), g);
            end
         end
      end

      repeat (TMO + 8) step(1'b0, 8'h00);
      @(negedge clk);
      chk("leftover_events", evq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
